// File: rtl/diffin_offset_cal.sv
// Offset-trim calibration controller for differential input buffers.
// Sweeps each channel's trim code and keeps the first code that resolves high.
module diffin_offset_cal #(
    parameter int NCH           = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [NCH-1:0]   o_in,
    output logic [4*NCH-1:0] osc,
    output logic [2*NCH-1:0] osc_en,
    output logic [NCH-1:0]   err
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [8:0] SAMPLE_N = 9'(SAMPLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE, SET, SETTLE, SAMPLE, EVAL, NEXT_CH, DONE
    } state_t;

    state_t         state, state_d;
    logic [CHW-1:0] ch;
    logic [3:0]     idx;
    logic [7:0]     cnt;
    logic [7:0]     ones;
    logic [NCH-1:0] sync1, sync2;
    logic           sbit;
    logic           hit;

    // Sweep index 0..14 maps to -7..+7 in sign/magnitude form.
    function automatic logic [3:0] code_of(input logic [3:0] i);
        if (i >= 4'd7)
            return {1'b1, 3'(i - 4'd7)};
        else
            return {1'b0, 3'(4'd7 - i)};
    endfunction

    assign sbit = sync2[ch];
    assign hit  = {ones, 1'b0} > SAMPLE_N;
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = SET;
            SET:     state_d = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE:  if (cnt == SAMPLE_LAST) state_d = EVAL;
            EVAL:    state_d = (hit || idx == 4'd14) ? NEXT_CH : SET;
            NEXT_CH: state_d = (ch == LAST_CH) ? DONE : SET;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            ch     <= '0;
            idx    <= '0;
            cnt    <= '0;
            ones   <= '0;
            osc    <= {NCH{4'b1000}};
            osc_en <= '0;
            err    <= '0;
        end else begin
            sync1 <= o_in;
            sync2 <= sync1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ch  <= '0;
                        idx <= '0;
                        err <= '0;
                    end
                end
                SET: begin
                    osc[4*ch +: 4]    <= code_of(idx);
                    osc_en[2*ch +: 2] <= 2'b11;
                    cnt               <= '0;
                    ones              <= '0;
                end
                SETTLE: begin
                    cnt <= (cnt == SETTLE_LAST) ? 8'd0 : cnt + 8'd1;
                end
                SAMPLE: begin
                    cnt  <= (cnt == SAMPLE_LAST) ? 8'd0 : cnt + 8'd1;
                    ones <= ones + 8'(sbit);
                end
                EVAL: begin
                    // The driven code already equals the result in every exit case.
                    if (hit) begin
                        if (idx == 4'd0)
                            err[ch] <= 1'b1;
                    end else if (idx == 4'd14) begin
                        err[ch] <= 1'b1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                NEXT_CH: begin
                    osc_en[2*ch +: 2] <= 2'b00;
                    if (ch != LAST_CH) begin
                        ch  <= ch + CHW'(1);
                        idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diffin_offset_cal.sv
// Bench for diffin_offset_cal: behavioural buffer model with per-channel
// offsets, scoreboard of expected trim/err results popped on done.
module tb_diffin_offset_cal;
    localparam int NCH  = 8;
    localparam int ST   = 16;
    localparam int SM   = 8;
    localparam int STEP = ST + SM + 2;
    localparam int LIMIT = 5000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic [NCH-1:0]   o_in;
    logic [4*NCH-1:0] osc;
    logic [2*NCH-1:0] osc_en;
    logic [NCH-1:0]   err;

    int offset [NCH];
    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int bad_en = 0;
    int t_en0 = -1;
    int t_en1 = -1;
    logic [1:0] en0_q = 2'b00;
    logic [1:0] en1_q = 2'b00;

    typedef struct {
        logic [4*NCH-1:0] osc;
        logic [NCH-1:0]   err;
        int               cycles;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    diffin_offset_cal #(
        .NCH(NCH),
        .SETTLE_CYCLES(ST),
        .SAMPLE_CYCLES(SM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .o_in(o_in),
        .osc(osc),
        .osc_en(osc_en),
        .err(err)
    );

    function automatic int trim_val(input logic [3:0] c);
        int m;
        m = int'(c[2:0]);
        return c[3] ? m : -m;
    endfunction

    // Buffer model: output high when trim*5 + offset is positive.
    always @* begin
        for (int k = 0; k < NCH; k++)
            o_in[k] = (osc_en[2*k +: 2] == 2'b11) &&
                      (trim_val(osc[4*k +: 4]) * 5 + offset[k] > 0);
    end

    always @(negedge clk) begin
        int n;
        n = 0;
        cyc <= cyc + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        for (int k = 0; k < NCH; k++) begin
            if (osc_en[2*k +: 2] == 2'b01 || osc_en[2*k +: 2] == 2'b10)
                n = n + 2;
            if (osc_en[2*k +: 2] == 2'b11)
                n = n + 1;
        end
        if (n > 1) bad_en <= bad_en + 1;
        if (osc_en[1:0] == 2'b11 && en0_q != 2'b11) t_en0 <= cyc;
        if (osc_en[3:2] == 2'b11 && en1_q != 2'b11) t_en1 <= cyc;
        en0_q <= osc_en[1:0];
        en1_q <= osc_en[3:2];
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model(output exp_t e);
        int steps;
        int v;
        logic found;
        logic [3:0] code;
        e.osc = '0;
        e.err = '0;
        e.cycles = 0;
        for (int k = 0; k < NCH; k++) begin
            found = 1'b0;
            steps = 15;
            code = 4'b1111;
            for (int i = 0; i < 15; i++) begin
                v = i - 7;
                if (!found && v * 5 + offset[k] > 0) begin
                    found = 1'b1;
                    steps = i + 1;
                    code = (v < 0) ? {1'b0, 3'(-v)} : {1'b1, 3'(v)};
                end
            end
            e.osc[4*k +: 4] = code;
            e.err[k] = !found || steps == 1;
            e.cycles += steps * STEP + 1;
        end
    endtask

    task automatic calibrate(input string tag, input int restart_at,
                             output exp_t got);
        exp_t e;
        int b0, d0, e0;
        logic seen;
        model(e);
        sb.push_back(e);
        b0 = busy_cnt;
        d0 = done_cnt;
        e0 = bad_en;
        seen = 1'b0;
        start = 1'b1;
        for (int n = 0; n < LIMIT && !seen; n++) begin
            tick();
            start = (n == restart_at) ? 1'b1 : 1'b0;
            if (n == 0 || n == restart_at + 1) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_hold n=%0d got %b want 1", tag, n, busy);
                end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s done_timeout got none want pulse within %0d", tag, LIMIT);
            got = e;
            return;
        end
        e = sb.pop_front();
        got = e;
        vectors++;
        if (osc !== e.osc) begin
            miscompares++;
            $display("FAIL %s osc got %h want %h", tag, osc, e.osc);
        end
        vectors++;
        if (err !== e.err) begin
            miscompares++;
            $display("FAIL %s err got %b want %b", tag, err, e.err);
        end
        tick();
        vectors++;
        if (busy_cnt - b0 !== e.cycles) begin
            miscompares++;
            $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cnt - b0, e.cycles);
        end
        vectors++;
        if (done_cnt - d0 !== 1 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_once got %0d/%b/%b want 1/0/0", tag,
                     done_cnt - d0, done, busy);
        end
        vectors++;
        if (bad_en - e0 !== 0) begin
            miscompares++;
            $display("FAIL %s osc_en_legal got %0d bad cycles want 0", tag, bad_en - e0);
        end
    endtask

    task automatic set_offsets(input int base, input int ch, input int val);
        for (int k = 0; k < NCH; k++) offset[k] = base;
        offset[ch] = val;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_done got %b/%b want 0/0", tag, busy, done);
        end
        vectors++;
        if (err !== '0) begin
            miscompares++;
            $display("FAIL %s err got %b want 0", tag, err);
        end
        vectors++;
        if (osc !== {NCH{4'b1000}}) begin
            miscompares++;
            $display("FAIL %s osc got %h want %h", tag, osc, {NCH{4'b1000}});
        end
        vectors++;
        if (osc_en !== '0) begin
            miscompares++;
            $display("FAIL %s osc_en got %h want 0", tag, osc_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        set_offsets(-40, 0, -40);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_ch0_pos();
        exp_t g;
        set_offsets(-40, 0, 12);
        calibrate("ch0_pos", -10, g);
        vectors++;
        if (osc[3:0] !== 4'b0010 || err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ch0_pos code got %b/%b want 0010/0", osc[3:0], err[0]);
        end
        vectors++;
        if (osc[31:4] !== {7{4'b1111}} || err[7:1] !== 7'h7f) begin
            miscompares++;
            $display("FAIL ch0_pos others got %h/%b want fffffff/1111111",
                     osc[31:4], err[7:1]);
        end
    endtask

    task automatic test_ch0_neg();
        exp_t g;
        set_offsets(-40, 0, -12);
        calibrate("ch0_neg", -10, g);
        vectors++;
        if (osc[3:0] !== 4'b1011 || err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ch0_neg code got %b/%b want 1011/0", osc[3:0], err[0]);
        end
        vectors++;
        if (t_en1 - t_en0 !== 287) begin
            miscompares++;
            $display("FAIL ch0_neg ch_cost got %0d want 287", t_en1 - t_en0);
        end
    endtask

    task automatic test_ch2_pos40();
        exp_t g;
        set_offsets(0, 2, 40);
        calibrate("ch2_pos40", -10, g);
        vectors++;
        if (osc[11:8] !== 4'b0111 || err[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL ch2_pos40 got %b/%b want 0111/1", osc[11:8], err[2]);
        end
        vectors++;
        if (osc[3:0] !== 4'b1001 || err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ch2_pos40 ch0 got %b/%b want 1001/0", osc[3:0], err[0]);
        end
    endtask

    task automatic test_ch5_neg40();
        exp_t g;
        set_offsets(7, 5, -40);
        calibrate("ch5_neg40", -10, g);
        vectors++;
        if (osc[23:20] !== 4'b1111 || err[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL ch5_neg40 got %b/%b want 1111/1", osc[23:20], err[5]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t g;
        set_offsets(-3, 4, 22);
        offset[6] = 33;
        calibrate("restart_ignored", 100, g);
        repeat (50) tick();
        vectors++;
        if (osc !== g.osc || err !== g.err) begin
            miscompares++;
            $display("FAIL persist_idle got %h/%b want %h/%b", osc, err, g.osc, g.err);
        end
    endtask

    task automatic test_reset_mid();
        exp_t g;
        int c0;
        logic seen;
        set_offsets(-40, 1, 40);
        offset[0] = 0;
        offset[2] = -12;
        seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < LIMIT && !seen; n++) begin
            tick();
            if (osc_en[7:6] === 2'b11) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_mid ch3_timeout got none want ch3 enabled");
        end
        repeat (18) tick();
        vectors++;
        if (err[1] !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid pre got err1=%b busy=%b want 1/1", err[1], busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        tick();
        rst_n = 1'b1;
        tick();
        c0 = cyc;
        calibrate("after_reset", -10, g);
        vectors++;
        if (!(t_en0 > c0 && t_en1 > t_en0)) begin
            miscompares++;
            $display("FAIL after_reset order got en0=%0d en1=%0d want %0d<en0<en1",
                     t_en0, t_en1, c0);
        end
    endtask

    initial begin
        test_reset();
        test_ch0_pos();
        test_ch0_neg();
        test_ch2_pos40();
        test_ch5_neg40();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/diffin_offset_cal.md
Name: diffin_offset_cal

Overview:
- Multi-channel offset-calibration controller for differential input buffers that expose a 4-bit offset-trim code (OSC) and a 2-bit oscillator/calibration enable (OSC_EN).
- On a start request it calibrates each channel in turn. For each channel it enables calibration mode, sweeps the trim code from most-negative to most-positive, and majority-samples the buffer output. It records the first code at which the output resolves high.
- Sits between the PHY input-buffer array and the DDR training sequencer. After calibration the recorded codes stay applied to the buffers.

Parameters:
- NCH, 8, number of differential input channels calibrated.
- SETTLE_CYCLES, 16, cycles waited after each code change before sampling; legal range 3..255.
- SAMPLE_CYCLES, 8, cycles the output is sampled per code; legal range 1..255.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a full calibration.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse when the last channel has finished.
- o_in  input  NCH  buffer O outputs, asynchronous to clk.
- osc  output  4*NCH  per-channel trim code. Bits [4k+3:4k] belong to channel k. Bit 3 is the sign (1 = positive); bits 2:0 are the magnitude in 5-unit steps.
- osc_en  output  2*NCH  per-channel enable. Bits [2k+1:2k] belong to channel k.
- err  output  NCH  per-channel out-of-range flag, valid from done until the next start.

Behaviour:
- Reset values:
  - busy=0, done=0, err=0.
  - All osc nibbles = 4'b1000 (+0).
  - All osc_en = 2'b00.
  - FSM in IDLE; counters and synchronizers cleared.
- o_in passes through a 2-flop synchronizer per channel before use.
- Sweep index i runs 0..14, mapped to signed value v = i-7.
  - Encoding: if v>=0, code = {1'b1, v[2:0]}; else code = {1'b0, (-v)[2:0]}.
  - Sequence: 0111, 0110, ..., 0001, 1000, 1001, ..., 1111.
  - Code 4'b0000 is never driven.
- FSM states: IDLE, SET, SETTLE, SAMPLE, EVAL, NEXT_CH, DONE.
  - IDLE: start=1 → SET with ch=0, i=0, clear err; busy rises next cycle. Any other start is ignored.
  - SET (1 cycle): drive osc[ch]=code(i) and osc_en[ch]=2'b11. All other channels keep osc_en=2'b00 and hold their osc value.
  - SETTLE: count SETTLE_CYCLES cycles, then → SAMPLE.
  - SAMPLE: count SAMPLE_CYCLES cycles, accumulating ones of the synchronized o_in[ch], then → EVAL.
  - EVAL (1 cycle): hit = (ones*2 > SAMPLE_CYCLES); ties count as 0.
    - hit and i==0: err[ch]=1, keep code 0111, → NEXT_CH.
    - hit and i>0: keep code(i), → NEXT_CH.
    - no hit and i<14: i++, → SET.
    - no hit and i==14: err[ch]=1, keep code 1111, → NEXT_CH.
  - NEXT_CH (1 cycle): osc_en[ch]=2'b00, osc[ch] retains its result. If ch==NCH-1 → DONE; else ch++, i=0, → SET.
  - DONE (1 cycle): done=1, busy=0 in the same cycle, → IDLE.
- Cycles per code step = SETTLE_CYCLES+SAMPLE_CYCLES+2.
- Channel cost = steps*(SETTLE_CYCLES+SAMPLE_CYCLES+2)+1.
- busy spans the sum of all channel costs; done follows the last NEXT_CH.
- osc_en is never 2'b01 or 2'b10, so buffer outputs are never forced to X by an illegal enable.
- start during busy/DONE: ignored, no restart.
- rst_n low mid-calibration: all outputs return to reset values immediately (asynchronously); a partial result is never retained.
- err and osc results persist in IDLE until the next accepted start. On that start, err clears and each channel's osc is overwritten only when that channel is calibrated.

Test Plan:
- Channel 0 model offset +12 (others offset -40), default params → osc[3:0]=4'b0010 after 6 steps, err[0]=0; channels 1..7 osc=4'b1111 with err set; done pulses exactly once.
- Channel 0 model offset -12 → osc[3:0]=4'b1011 (v=+3), err[0]=0; channel cost = 11*26+1=287 cycles, checked between start and the move to channel 1.
- Offset +40 on channel 2 → err[2]=1 and osc[11:8]=4'b0111 after a single step.
- Offset -40 on channel 5 → err[5]=1 and osc[23:20]=4'b1111 after 15 steps.
- start pulsed again at cycle 100 of busy → ignored: busy stays high, one done, results identical. osc_en never shows 01/10 and at most one channel is 11 at any time.
- rst_n asserted during channel 3 SAMPLE → next edge-independent state: busy=0, osc all 4'b1000, osc_en all 00, err=0. A subsequent start recalibrates all channels from channel 0.
